// File: rtl/fpu_sched.sv
// rtl/fpu_sched.sv - single-issue FPU operation scheduler with per-class fixed latency
//
// Accepts one FPU op at a time from the core, registers the op and operands onto the
// FPU datapath, waits the latency associated with funct7, captures the FPU result and
// holds it until the core takes it.
//
// Parameters: LAT_ADD (funct7 0x00/0x04), LAT_MUL (0x08), LAT_DIV (0x0C), LAT_CVT (0x68),
//             LAT_MISC (any other funct7); each in 1..15 cycles from accept to result.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_ready              op handshake (ready only when idle)
//   req_funct3/funct7/x1/x2/rd       op, operands and destination tag
//   fpu_funct3/funct7/x1/x2          registered op/operands to the FPU datapath
//   fpu_y                            FPU result
//   resp_valid/resp_ready            result handshake
//   resp_data/resp_rd                captured result and its tag
//   busy                             high whenever not idle
//   flush                            abort in-flight op (only with FPU_SCHED_FLUSH_EN)
// Build option: define FPU_SCHED_FLUSH_EN to add the flush port and its logic.

module fpu_sched #(
    parameter int unsigned LAT_ADD  = 2,
    parameter int unsigned LAT_MUL  = 1,
    parameter int unsigned LAT_DIV  = 4,
    parameter int unsigned LAT_CVT  = 1,
    parameter int unsigned LAT_MISC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [6:0]  req_funct7,
    input  logic [31:0] req_x1,
    input  logic [31:0] req_x2,
    input  logic [4:0]  req_rd,
    output logic [2:0]  fpu_funct3,
    output logic [6:0]  fpu_funct7,
    output logic [31:0] fpu_x1,
    output logic [31:0] fpu_x2,
    input  logic [31:0] fpu_y,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
`ifdef FPU_SCHED_FLUSH_EN
    input  logic        flush,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic [6:0]  f7_q, f7_d;
    logic [31:0] x1_q, x1_d;
    logic [31:0] x2_q, x2_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_q, data_d;

    // Counter preload is latency minus one: the capture edge itself is the last cycle.
    function automatic logic [3:0] lat_m1(input logic [6:0] f7);
        logic [3:0] lat;
        case (f7)
            7'h00, 7'h04: lat = 4'(LAT_ADD);
            7'h08:        lat = 4'(LAT_MUL);
            7'h0C:        lat = 4'(LAT_DIV);
            7'h68:        lat = 4'(LAT_CVT);
            default:      lat = 4'(LAT_MISC);
        endcase
        return lat - 4'd1;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        f7_d    = f7_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        rd_d    = rd_q;
        data_d  = data_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    f3_d    = req_funct3;
                    f7_d    = req_funct7;
                    x1_d    = req_x1;
                    x2_d    = req_x2;
                    rd_d    = req_rd;
                    cnt_d   = lat_m1(req_funct7);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    data_d  = fpu_y;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef FPU_SCHED_FLUSH_EN
        // Flush cancels everything this edge would have done: no accept in IDLE,
        // no capture in BUSY, no response in DONE.
        if (flush) begin
            state_d = IDLE;
            cnt_d   = cnt_q;
            f3_d    = f3_q;
            f7_d    = f7_q;
            x1_d    = x1_q;
            x2_d    = x2_q;
            rd_d    = rd_q;
            data_d  = data_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            f3_q    <= 3'd0;
            f7_q    <= 7'd0;
            x1_q    <= 32'd0;
            x2_q    <= 32'd0;
            rd_q    <= 5'd0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            f7_q    <= f7_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == DONE);
    assign fpu_funct3 = f3_q;
    assign fpu_funct7 = f7_q;
    assign fpu_x1     = x1_q;
    assign fpu_x2     = x2_q;
    assign resp_data  = data_q;
    assign resp_rd    = rd_q;

endmodule

// File: tb/tb_fpu_sched.sv
// tb/tb_fpu_sched.sv - randomized scoreboard bench for fpu_sched

module tb_fpu_sched;

    localparam int L_ADD  = 2;
    localparam int L_MUL  = 1;
    localparam int L_DIV  = 4;
    localparam int L_CVT  = 2;
    localparam int L_MISC = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [6:0]  req_funct7;
    logic [31:0] req_x1, req_x2;
    logic [4:0]  req_rd;
    logic [2:0]  fpu_funct3;
    logic [6:0]  fpu_funct7;
    logic [31:0] fpu_x1, fpu_x2;
    logic [31:0] fpu_y;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        busy;
    logic        flush_s;

    always #5 clk = ~clk;

    fpu_sched #(
        .LAT_ADD(L_ADD), .LAT_MUL(L_MUL), .LAT_DIV(L_DIV), .LAT_CVT(L_CVT), .LAT_MISC(L_MISC)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_funct3(req_funct3), .req_funct7(req_funct7),
        .req_x1(req_x1), .req_x2(req_x2), .req_rd(req_rd),
        .fpu_funct3(fpu_funct3), .fpu_funct7(fpu_funct7),
        .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_y(fpu_y),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_rd(resp_rd),
`ifdef FPU_SCHED_FLUSH_EN
        .flush(flush_s),
`endif
        .busy(busy)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lat_of(input logic [6:0] f7);
        if (f7 == 7'h00 || f7 == 7'h04) return L_ADD;
        if (f7 == 7'h08) return L_MUL;
        if (f7 == 7'h0C) return L_DIV;
        if (f7 == 7'h68) return L_CVT;
        return L_MISC;
    endfunction

    // Stand-in FPU: real results for the known float cases, a hash otherwise.
    function automatic logic [31:0] fpu_ref(input logic [6:0] f7, input logic [31:0] a,
                                            input logic [31:0] b);
        if (f7 == 7'h00 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (f7 == 7'h08 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (f7 == 7'h0C && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        return a ^ {b[15:0], b[31:16]} ^ {25'd0, f7};
    endfunction

    // Reference model: one transaction in flight, timed by cycle numbers.
    bit          m_in    = 1'b0;
    bit          m_clean = 1'b1;
    int          m_acc   = 0;
    int          m_lat   = 1;
    logic [2:0]  m_f3    = '0;
    logic [6:0]  m_f7    = '0;
    logic [31:0] m_x1    = '0;
    logic [31:0] m_x2    = '0;
    logic [4:0]  m_rd    = '0;
    logic [31:0] m_resp  = '0;

    always @(negedge clk) begin
        bit ev;
        cyc++;
        ev = m_in && (cyc - m_acc > m_lat);
        if (cyc > 1) begin
            check("req_ready", 32'(req_ready), 32'(!m_in));
            check("busy", 32'(busy), 32'(m_in));
            check("resp_valid", 32'(resp_valid), 32'(ev));
            check("fpu_funct3", 32'(fpu_funct3), 32'(m_f3));
            check("fpu_funct7", 32'(fpu_funct7), 32'(m_f7));
            check("fpu_x1", fpu_x1, m_x1);
            check("fpu_x2", fpu_x2, m_x2);
            if (ev || m_clean) begin
                check("resp_data", resp_data, m_resp);
                check("resp_rd", 32'(resp_rd), 32'(m_rd));
            end
        end
        // Result is only correct in the cycle right before the expected capture edge.
        if (m_in && (cyc - m_acc == m_lat)) fpu_y = fpu_ref(m_f7, m_x1, m_x2);
        else                                fpu_y = ~fpu_ref(m_f7, m_x1, m_x2);

        if (rst) begin
            m_in = 1'b0; m_clean = 1'b1;
            m_f3 = '0; m_f7 = '0; m_x1 = '0; m_x2 = '0; m_rd = '0; m_resp = '0;
            sb.delete();
        end else if (flush_s) begin
            if (m_in) begin
                m_in = 1'b0;
                sb.delete();
            end
        end else if (m_in) begin
            if (cyc - m_acc == m_lat) m_resp = fpu_ref(m_f7, m_x1, m_x2);
            if (ev && resp_ready) m_in = 1'b0;
        end else if (req_valid) begin
            m_in = 1'b1; m_clean = 1'b0;
            m_acc = cyc; m_lat = lat_of(req_funct7);
            m_f3 = req_funct3; m_f7 = req_funct7; m_x1 = req_x1; m_x2 = req_x2; m_rd = req_rd;
            sb.push_back('{fpu_ref(req_funct7, req_x1, req_x2), req_rd, cyc, m_lat});
        end
    end

    // Monitor: pops one expected response each time resp_valid rises.
    bit prev_v = 1'b0;
    always @(posedge clk) begin
        exp_t e;
        #3;
        if (resp_valid === 1'b1 && !prev_v) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got response %h with no expected entry (cycle %0d)",
                         resp_data, cyc);
            end else begin
                e = sb.pop_front();
                check("sb_data", resp_data, e.data);
                check("sb_rd", 32'(resp_rd), 32'(e.rd));
                check("sb_latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
        prev_v = (resp_valid === 1'b1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        int i;
        req_funct7 = f7; req_funct3 = f3; req_x1 = a; req_x2 = b; req_rd = rd;
        req_valid = 1'b1;
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        if (i == 50) check("issue_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int i;
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (resp_valid) break;
        end
        if (i == 50) check("resp_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] f7_tab [6];
        f7_tab[0] = 7'h00; f7_tab[1] = 7'h04; f7_tab[2] = 7'h08;
        f7_tab[3] = 7'h0C; f7_tab[4] = 7'h68; f7_tab[5] = 7'h10;

        rst = 1'b1; flush_s = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_funct3 = '0; req_funct7 = '0; req_x1 = '0; req_x2 = '0; req_rd = '0;
        fpu_y = '0;
        step(3);
        rst = 1'b0;

        // fadd, fmul with resp_ready held, fdiv with backpressure
        resp_ready = 1'b1;
        issue(7'h00, 3'd0, 32'h3F800000, 32'h40000000, 5'd5);
        step(5);
        issue(7'h08, 3'd0, 32'h40000000, 32'h40400000, 5'd7);
        step(3);
        resp_ready = 1'b0;
        issue(7'h0C, 3'd0, 32'h40C00000, 32'h40000000, 5'd9);
        wait_valid();
        step(2);
        resp_ready = 1'b1;
        step(2);

        // Back-to-back with req_valid held high
        resp_ready = 1'b0;
        issue(7'h04, 3'd1, 32'h12345678, 32'h9ABCDEF0, 5'd3);
        req_valid = 1'b1;
        req_funct7 = 7'h68; req_funct3 = 3'd2; req_x1 = 32'hCAFEF00D; req_x2 = 32'h0BADBEEF;
        req_rd = 5'd31;
        step(8);
        resp_ready = 1'b1;
        step(10);
        req_valid = 1'b0;
        step(2);

        // Reset in the middle of an fdiv
        issue(7'h0C, 3'd0, 32'h40C00000, 32'h40000000, 5'd11);
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(4);

`ifdef FPU_SCHED_FLUSH_EN
        issue(7'h0C, 3'd0, 32'h40C00000, 32'h40000000, 5'd12);
        flush_s = 1'b1;
        step(1);
        flush_s = 1'b0;
        step(2);
        issue(7'h00, 3'd0, 32'h3F800000, 32'h40000000, 5'd13);
        step(5);
        req_valid = 1'b1; flush_s = 1'b1;
        step(2);
        req_valid = 1'b0; flush_s = 1'b0;
        step(2);
`endif

        // Random traffic
        for (int k = 0; k < 800; k++) begin
            rst        = ($urandom_range(0, 99) == 0);
`ifdef FPU_SCHED_FLUSH_EN
            flush_s    = ($urandom_range(0, 39) == 0);
`endif
            req_valid  = $urandom_range(0, 1) == 1;
            req_funct7 = ($urandom_range(0, 7) == 0) ? 7'($urandom) : f7_tab[$urandom_range(0, 5)];
            req_funct3 = 3'($urandom);
            req_x1     = $urandom;
            req_x2     = $urandom;
            req_rd     = 5'($urandom);
            resp_ready = $urandom_range(0, 2) != 0;
            step(1);
        end

        rst = 1'b0; flush_s = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        step(20);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
